// File: rtl/dot_pkg.sv
// Shared types and helpers for the dot-product operand stream buffer.
package dot_pkg;

  localparam int DOT_DATA_WIDTH = 8;
  // Widest element index the beat tag can carry
  localparam int TAG_IDX_W      = 16;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [TAG_IDX_W-1:0] elem_idx;
  } beat_tag_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dot_pingpong_bank.sv
// Two-bank element store: synchronous single-element write,
// combinational LANES-wide read starting at an element index.
module dot_pingpong_bank
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = DOT_DATA_WIDTH,
  parameter int VECTOR_LEN = 4,
  parameter int LANES      = 1,
  parameter int IDX_W      = 2
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic                        wr_bank,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_bank,
  input  logic [IDX_W-1:0]            rd_base,
  output logic [LANES*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2][VECTOR_LEN];

  // Element write; storage is deliberately left without reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
  end

  // Gather LANES consecutive elements, lane 0 in the LSBs
  always_comb begin
    rd_data = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_data[l*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][rd_base + IDX_W'(l)];
    end
  end

endmodule

// File: rtl/dot_vector_stream_buffer.sv
// Ping-pong operand buffer for the dot-product MAC: host writes A/B element
// pairs into one bank while the other bank streams out as LANES-wide beats.
module dot_vector_stream_buffer
  import dot_pkg::*;
#(
  parameter  int DATA_WIDTH = DOT_DATA_WIDTH,
  parameter  int VECTOR_LEN = 4,
  parameter  int LANES      = 1,
  parameter  int CNT_WIDTH  = 16,
  localparam int BEATS      = VECTOR_LEN / LANES,
  localparam int IDX_W      = (clog2(VECTOR_LEN) < 1) ? 1 : clog2(VECTOR_LEN),
  localparam int BEAT_W     = (clog2(BEATS) < 1) ? 1 : clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DATA_WIDTH-1:0]       wr_data_a,
  input  logic [DATA_WIDTH-1:0]       wr_data_b,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [LANES*DATA_WIDTH-1:0] rd_data_a,
  output logic [LANES*DATA_WIDTH-1:0] rd_data_b,
  output logic                        rd_first,
  output logic                        rd_last,
  output logic [IDX_W-1:0]            rd_elem_idx,
  output logic [1:0]                  bank_full,
  output logic [CNT_WIDTH-1:0]        vec_count
);

  logic                        wr_bank, rd_bank;
  logic [IDX_W-1:0]            wr_idx;
  logic [BEAT_W-1:0]           rd_beat;
  logic [1:0]                  full, full_nxt;
  logic                        wr_fire, wr_done, ld, ld_last, rd_fire, beat_is_last;
  logic [IDX_W-1:0]            rd_base;
  logic [LANES*DATA_WIDTH-1:0] bank_a, bank_b;

  logic                        vld_p1;
  logic [LANES*DATA_WIDTH-1:0] data_a_p1, data_b_p1;
  beat_tag_t                   tag_p1;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        unused_tag_bits;

  dot_pingpong_bank #(
    .DATA_WIDTH(DATA_WIDTH), .VECTOR_LEN(VECTOR_LEN), .LANES(LANES), .IDX_W(IDX_W)
  ) u_bank_a (
    .clk(clk), .wr_en(wr_fire), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data_a),
    .rd_bank(rd_bank), .rd_base(rd_base), .rd_data(bank_a)
  );

  dot_pingpong_bank #(
    .DATA_WIDTH(DATA_WIDTH), .VECTOR_LEN(VECTOR_LEN), .LANES(LANES), .IDX_W(IDX_W)
  ) u_bank_b (
    .clk(clk), .wr_en(wr_fire), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data_b),
    .rd_bank(rd_bank), .rd_base(rd_base), .rd_data(bank_b)
  );

  // Handshake decode and full-flag update; flush masks every transfer
  always_comb begin
    wr_ready     = !full[wr_bank];
    wr_fire      = wr_valid && !full[wr_bank] && !flush;
    wr_done      = wr_fire && (wr_idx == IDX_W'(VECTOR_LEN - 1));
    rd_fire      = vld_p1 && rd_ready;
    ld           = full[rd_bank] && (!vld_p1 || rd_ready) && !flush;
    beat_is_last = (rd_beat == BEAT_W'(BEATS - 1));
    ld_last      = ld && beat_is_last;
    rd_base      = IDX_W'(int'(rd_beat) * LANES);
    full_nxt     = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (ld_last) full_nxt[rd_bank] = 1'b0;
  end

  // Write/read pointers and per-bank full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_beat <= '0;
      full    <= 2'b00;
    end else if (flush) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_beat <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_done) begin
        wr_bank <= !wr_bank;
        wr_idx  <= '0;
      end else if (wr_fire) begin
        wr_idx  <= wr_idx + IDX_W'(1);
      end
      if (ld_last) begin
        rd_bank <= !rd_bank;
        rd_beat <= '0;
      end else if (ld) begin
        rd_beat <= rd_beat + BEAT_W'(1);
      end
    end
  end

  // ---- stage p1: registered output beat, held while the consumer stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      tag_p1    <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      tag_p1    <= '0;
    end else if (ld) begin
      vld_p1          <= 1'b1;
      data_a_p1       <= bank_a;
      data_b_p1       <= bank_b;
      tag_p1.first    <= (rd_beat == '0);
      tag_p1.last     <= beat_is_last;
      tag_p1.elem_idx <= TAG_IDX_W'(rd_base);
    end else if (rd_fire) begin
      vld_p1 <= 1'b0;
    end
  end

  // Delivered-vector counter, survives flush and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rd_fire && tag_p1.last && !flush) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign unused_tag_bits = ^tag_p1.elem_idx;
  assign rd_valid        = vld_p1;
  assign rd_data_a       = data_a_p1;
  assign rd_data_b       = data_b_p1;
  assign rd_first        = tag_p1.first;
  assign rd_last         = tag_p1.last;
  assign rd_elem_idx     = tag_p1.elem_idx[IDX_W-1:0];
  assign bank_full       = full;
  assign vec_count       = cnt;

endmodule

// File: tb/tb_dot_vector_stream_buffer.sv
// Scoreboard bench for dot_vector_stream_buffer (VECTOR_LEN=8, LANES=2).
module tb_dot_vector_stream_buffer;

  localparam int DW    = 8;
  localparam int VL    = 8;
  localparam int LN    = 2;
  localparam int CW    = 4;
  localparam int BEATS = VL / LN;
  localparam int IDX_W = 3;
  localparam int LW    = LN * DW;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic [LW-1:0] rd_data_a, rd_data_b;
  logic          rd_first, rd_last;
  logic [IDX_W-1:0] rd_elem_idx;
  logic [1:0]    bank_full;
  logic [CW-1:0] vec_count;

  always #5 clk = ~clk;

  dot_vector_stream_buffer #(
    .DATA_WIDTH(DW), .VECTOR_LEN(VL), .LANES(LN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_first(rd_first), .rd_last(rd_last), .rd_elem_idx(rd_elem_idx),
    .bank_full(bank_full), .vec_count(vec_count)
  );

  typedef struct {
    logic [LW-1:0]    a, b;
    logic             first, last;
    logic [IDX_W-1:0] idx;
  } beat_t;

  beat_t         sb_q[$];
  beat_t         mon_e, hold_b;
  logic          hold_v;
  logic [DW-1:0] part_a[VL], part_b[VL];
  int            part_n;
  logic [CW-1:0] exp_cnt;
  int            n_chk = 0, n_fail = 0;
  logic          rand_rd;
  int            stalls;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: inputs and outputs are stable at negedge, so what is seen here
  // is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete(); part_n = 0; exp_cnt = '0; hold_v = 1'b0;
    end else if (flush) begin
      sb_q.delete(); part_n = 0; hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_a", rd_data_a, hold_b.a);
        chk("hold_b", rd_data_b, hold_b.b);
        chk("hold_meta", {rd_valid, rd_first, rd_last, rd_elem_idx},
            {1'b1, hold_b.first, hold_b.last, hold_b.idx});
      end
      chk("vec_count", vec_count, exp_cnt);
      if (rd_valid) chk("spurious_beat", sb_q.size() != 0, 1'b1);
      if (rd_valid && rd_ready && sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("beat_a", rd_data_a, mon_e.a);
        chk("beat_b", rd_data_b, mon_e.b);
        chk("beat_meta", {rd_first, rd_last, rd_elem_idx}, {mon_e.first, mon_e.last, mon_e.idx});
        if (mon_e.last) exp_cnt = exp_cnt + 1'b1;
      end
      hold_v   = rd_valid && !rd_ready;
      hold_b.a = rd_data_a;  hold_b.b = rd_data_b;
      hold_b.first = rd_first; hold_b.last = rd_last; hold_b.idx = rd_elem_idx;
      if (wr_valid && wr_ready) begin
        part_a[part_n] = wr_data_a;
        part_b[part_n] = wr_data_b;
        part_n++;
        if (part_n == VL) begin
          for (int k = 0; k < BEATS; k++) begin
            for (int l = 0; l < LN; l++) begin
              mon_e.a[l*DW +: DW] = part_a[k*LN + l];
              mon_e.b[l*DW +: DW] = part_b[k*LN + l];
            end
            mon_e.first = (k == 0);
            mon_e.last  = (k == BEATS - 1);
            mon_e.idx   = IDX_W'(k * LN);
            sb_q.push_back(mon_e);
          end
          part_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_elem(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int   guard;
    logic acc;
    wr_valid = 1'b1; wr_data_a = a; wr_data_b = b; guard = 0;
    do begin
      if (rand_rd) rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = wr_ready;
      step();
      guard++;
      if (!acc) stalls++;
    end while (!acc && guard < 200);
    wr_valid = 1'b0;
    if (guard >= 200) chk("write_timeout", acc, 1'b1);
  endtask

  task automatic write_vec(input logic [DW-1:0] a0, input logic [DW-1:0] b0);
    for (int i = 0; i < VL; i++) push_elem(a0 + DW'(i), b0 + DW'(i));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || rd_valid) && g < 500) begin
      if (rand_rd) rd_ready = 1'($urandom_range(0, 1));
      step();
      g++;
    end
    chk("drain_timeout", g < 500, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_data_a = '0; wr_data_b = '0; rand_rd = 1'b0; stalls = 0;

    // Reset held with random inputs
    repeat (4) begin
      wr_valid = 1'($urandom_range(0, 1)); rd_ready = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      wr_data_a = DW'($urandom); wr_data_b = DW'($urandom);
      step();
    end
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_bank_full", bank_full, 2'b00);
    chk("rst_vec_count", vec_count, '0);
    chk("rst_outputs", {rd_data_a, rd_data_b, rd_first, rd_last, rd_elem_idx}, '0);
    wr_valid = 1'b0; flush = 1'b0; rd_ready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_reset_idle", rd_valid, 1'b0);

    // Single vector with latency check and lane packing
    write_vec(8'h10, 8'h20);
    @(negedge clk);
    chk("latency_edge_e", rd_valid, 1'b0);
    chk("bank_full_set", bank_full, 2'b01);
    step();
    @(negedge clk);
    chk("latency_edge_e1", rd_valid, 1'b1);
    chk("lanes_beat0_a", rd_data_a, 16'h1110);
    chk("lanes_beat0_b", rd_data_b, 16'h2120);
    chk("lanes_beat0_meta", {rd_first, rd_last, rd_elem_idx}, {1'b1, 1'b0, 3'd0});
    drain();
    @(negedge clk);
    chk("single_count", vec_count, 4'd1);

    // Back-to-back vectors with the consumer always ready
    step();
    stalls = 0;
    for (int v = 0; v < 3; v++) write_vec(DW'(8'h30 + v * 16), DW'(8'h90 + v * 16));
    chk("b2b_no_stall", stalls, 0);
    drain();
    @(negedge clk);
    chk("b2b_count", vec_count, 4'd4);

    // Backpressure: both banks fill, output frozen on element 0
    step();
    rd_ready = 1'b0;
    write_vec(8'h40, 8'hC0);
    write_vec(8'h50, 8'hD0);
    @(negedge clk);
    chk("bp_wr_ready", wr_ready, 1'b0);
    chk("bp_bank_full", bank_full, 2'b11);
    chk("bp_frozen_a", {rd_valid, rd_data_a}, {1'b1, 16'h4140});
    repeat (3) step();
    rd_ready = 1'b1;
    write_vec(8'h60, 8'hE0);
    drain();
    @(negedge clk);
    chk("bp_count", vec_count, 4'd7);

    // Flush after a partial write, with a write offered in the flush cycle
    step();
    push_elem(8'h01, 8'h02);
    push_elem(8'h03, 8'h04);
    flush = 1'b1; wr_valid = 1'b1; wr_data_a = 8'hEE; wr_data_b = 8'hEE;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("flush_part_valid", rd_valid, 1'b0);
    chk("flush_part_full", bank_full, 2'b00);
    chk("flush_part_wr_ready", wr_ready, 1'b1);
    step();
    write_vec(8'h70, 8'hF0);
    drain();
    @(negedge clk);
    chk("flush_part_count", vec_count, 4'd8);

    // Flush during read-out
    step();
    rd_ready = 1'b0;
    write_vec(8'h80, 8'hA0);
    repeat (2) step();
    rd_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_rd_valid", rd_valid, 1'b0);
    chk("flush_rd_full", bank_full, 2'b00);
    chk("flush_rd_count", vec_count, 4'd8);
    step();
    write_vec(8'h21, 8'h43);
    drain();
    @(negedge clk);
    chk("after_flush_count", vec_count, 4'd9);

    // Async reset with one vector buffered and another partially written
    step();
    rd_ready = 1'b0;
    write_vec(8'h11, 8'h22);
    push_elem(8'h33, 8'h44);
    push_elem(8'h55, 8'h66);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rstpulse_valid", rd_valid, 1'b0);
    chk("rstpulse_full", bank_full, 2'b00);
    chk("rstpulse_count", vec_count, 4'd0);
    step();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    repeat (6) step();
    chk("rstpulse_no_beat", rd_valid, 1'b0);
    write_vec(8'hB0, 8'h0B);
    drain();
    @(negedge clk);
    chk("rstpulse_after_count", vec_count, 4'd1);

    // Random data and random consumer stalls; counter wraps past 15
    step();
    rand_rd = 1'b1;
    for (int v = 0; v < 18; v++) begin
      for (int i = 0; i < VL; i++) push_elem(DW'($urandom), DW'($urandom));
    end
    drain();
    rand_rd = 1'b0;
    rd_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("count_wrap", vec_count, 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
